// File: rtl/batch_mul_rr_sched.sv
// Round-robin scheduler that shares one signed x unsigned multiplier pipeline among N_REQ lanes.
// Optional counters stat_issues/stat_stall are built when BATCH_MUL_SCHED_STATS_EN is defined.
module batch_mul_rr_sched #(
    parameter int N_REQ     = 4,
    parameter int NUM_STAGE = 2,
    parameter int A_W       = 25,
    parameter int B_W       = 9,
    parameter int P_W       = 34
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic                   en,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*A_W-1:0]   req_a,
    input  logic [N_REQ*B_W-1:0]   req_b,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [P_W-1:0]         rsp_p,
    output logic                   busy
`ifdef BATCH_MUL_SCHED_STATS_EN
    ,
    output logic [31:0]            stat_issues,
    output logic [31:0]            stat_stall
`endif
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(N_REQ - 1);

    // Handshake contract: a lane transfers in the cycle req_valid[i] & req_ready[i];
    // req_ready is a function of en, reset, rr pointer and req_valid only.
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] w_gnt_idx;
    logic             w_found;
    int               w_scan;
    logic [N_REQ-1:0] w_hs;

    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_scan    = 0;
        req_ready = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan = int'(r_rr_ptr) + k;
            if (w_scan >= N_REQ) w_scan = w_scan - N_REQ;
            if (!w_found && req_valid[w_scan[PTR_W-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_scan[PTR_W-1:0];
            end
        end
        if (en && ap_rst_n && w_found) req_ready[w_gnt_idx] = 1'b1;
    end

    assign w_hs = req_valid & req_ready;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_rr_ptr <= '0;
        end else if (|w_hs) begin
            r_rr_ptr <= (w_gnt_idx == LAST_LANE) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // Stage 0 holds zeros when idle so the product, and hence rsp_p, is 0 without a valid.
    logic [A_W-1:0]   r_a;
    logic [B_W-1:0]   r_b;
    logic [N_REQ-1:0] r_tag [NUM_STAGE];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_a <= '0;
            r_b <= '0;
            for (int s = 0; s < NUM_STAGE; s++) r_tag[s] <= '0;
        end else begin
            r_a      <= (|w_hs) ? req_a[w_gnt_idx*A_W +: A_W] : '0;
            r_b      <= (|w_hs) ? req_b[w_gnt_idx*B_W +: B_W] : '0;
            r_tag[0] <= w_hs;
            for (int s = 1; s < NUM_STAGE; s++) r_tag[s] <= r_tag[s-1];
        end
    end

    logic [P_W-1:0] w_a_ext;
    logic [P_W-1:0] w_b_ext;
    logic [P_W-1:0] w_prod;

    // Low P_W bits of the extended unsigned product equal the signed product.
    assign w_a_ext = {{(P_W-A_W){r_a[A_W-1]}}, r_a};
    assign w_b_ext = {{(P_W-B_W){1'b0}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    generate
        if (NUM_STAGE == 1) begin : g_single
            assign rsp_p = w_prod;
        end else begin : g_multi
            logic [P_W-1:0] r_p [1:NUM_STAGE-1];
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    for (int s = 1; s < NUM_STAGE; s++) r_p[s] <= '0;
                end else begin
                    r_p[1] <= w_prod;
                    for (int s = 2; s < NUM_STAGE; s++) r_p[s] <= r_p[s-1];
                end
            end
            assign rsp_p = r_p[NUM_STAGE-1];
        end
    endgenerate

    assign rsp_valid = r_tag[NUM_STAGE-1];

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < NUM_STAGE; s++) busy = busy | (|r_tag[s]);
    end

`ifdef BATCH_MUL_SCHED_STATS_EN
    logic [31:0] r_stat_issues;
    logic [31:0] r_stat_stall;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_stat_issues <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (|w_hs) r_stat_issues <= r_stat_issues + 32'd1;
            if ((|req_valid) && !(|w_hs) && (r_stat_stall != 32'hFFFF_FFFF))
                r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign stat_issues = r_stat_issues;
    assign stat_stall  = r_stat_stall;
`endif

endmodule

// File: tb/tb_batch_mul_rr_sched.sv
// Bench for batch_mul_rr_sched: vector table, directed corner sequences and random traffic
// checked every cycle against a queue-based reference of grants and timed responses.
module tb_batch_mul_rr_sched;
  localparam int N  = 4;
  localparam int NS = 2;
  localparam int AW = 25;
  localparam int BW = 9;
  localparam int PW = 34;
  localparam int W  = 32 + N + PW;

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  logic en;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic [N-1:0] rsp_valid;
  logic [PW-1:0] rsp_p;
  logic busy;

  batch_mul_rr_sched #(.N_REQ(N), .NUM_STAGE(NS), .A_W(AW), .B_W(BW), .P_W(PW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_p(rsp_p), .busy(busy)
  );

  // clock / reset
  always #5 ap_clk = ~ap_clk;

  logic [AW-1:0] lane_a [N];
  logic [BW-1:0] lane_b [N];
  logic [N-1:0] lane_v;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int m_ptr = 0;
  logic [N-1:0] m_gnt;
  logic [N-1:0] dut_ready;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int lane;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [PW-1:0] p;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [PW-1:0] ref_mul(input logic [AW-1:0] a, input logic [BW-1:0] b);
    longint sa;
    longint p;
    sa = longint'($signed(a));
    p = sa * longint'(b);
    return p[PW-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_a[i*AW +: AW] = lane_a[i];
      req_b[i*BW +: BW] = lane_b[i];
    end
    req_valid = lane_v;
  endtask

  task automatic new_operands(input int i);
    case ($urandom_range(0, 7))
      0: lane_a[i] = 25'h1000000;
      1: lane_a[i] = 25'h0FFFFFF;
      2: lane_a[i] = 25'h1FFFFFF;
      default: lane_a[i] = AW'($urandom);
    endcase
    case ($urandom_range(0, 5))
      0: lane_b[i] = 9'd511;
      1: lane_b[i] = 9'd0;
      default: lane_b[i] = BW'($urandom);
    endcase
  endtask

  // Lanes hold valid and operands until the reference grant says they were taken.
  task automatic refresh(input int pct);
    for (int i = 0; i < N; i++) begin
      if (m_gnt[i]) lane_v[i] = 1'b0;
      if (!lane_v[i] && $urandom_range(0, 99) < pct) begin
        new_operands(i);
        lane_v[i] = 1'b1;
      end
    end
    drive();
  endtask

  // One clock: check at the falling edge against the reference, then advance past the rising edge.
  task automatic step();
    logic [N-1:0] er;
    logic [N-1:0] ev;
    logic [PW-1:0] ep;
    logic eb;
    logic [W-1:0] e;
    int g;
    @(negedge ap_clk);
    er = '0;
    g = -1;
    if (ap_rst_n && en) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    if (!ap_rst_n) begin
      exp_q.delete();
      m_ptr = 0;
    end
    eb = (exp_q.size() != 0);
    ev = '0;
    ep = '0;
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      if (e[W-1 -: 32] == 32'(cyc)) begin
        ev = e[PW +: N];
        ep = e[PW-1:0];
        void'(exp_q.pop_front());
      end
    end
    check("req_ready", 64'(req_ready), 64'(er));
    check("rsp_valid", 64'(rsp_valid), 64'(ev));
    check("rsp_p", 64'(rsp_p), 64'(ep));
    check("busy", 64'(busy), 64'(eb));
    dut_ready = req_ready;
    m_gnt = er;
    if (g >= 0) begin
      exp_q.push_back({32'(cyc + NS), er, ref_mul(lane_a[g], lane_b[g])});
      m_ptr = (g + 1) % N;
    end
    @(posedge ap_clk);
    #1;
    cyc++;
  endtask

  initial begin
    vecs[0] = '{2, 25'd100, 9'd3, 34'd300};
    vecs[1] = '{3, 25'h1FFFFFF, 9'd511, -34'sd511};
    vecs[2] = '{0, 25'h1000000, 9'd511, -34'sd8573157376};
    vecs[3] = '{1, 25'd12345, 9'd0, 34'd0};
    vecs[4] = '{2, 25'h0FFFFFF, 9'd511, 34'sd8573156865};
    vecs[5] = '{1, 25'h1FFFFF6, 9'd7, -34'sd70};

    for (int i = 0; i < N; i++) begin
      lane_a[i] = AW'(i + 1);
      lane_b[i] = BW'(i + 2);
    end
    m_gnt = '0;
    dut_ready = '0;

    // reset with every lane requesting
    ap_rst_n = 1'b0;
    en = 1'b1;
    lane_v = '1;
    drive();
    repeat (3) step();
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    lane_v = '0;
    drive();
    ap_rst_n = 1'b1;
    step();

    // table of single-lane products
    for (int v = 0; v < 6; v++) begin
      lane_a[vecs[v].lane] = vecs[v].a;
      lane_b[vecs[v].lane] = vecs[v].b;
      lane_v = '0;
      lane_v[vecs[v].lane] = 1'b1;
      drive();
      step();
      lane_v = '0;
      drive();
      repeat (NS - 1) step();
      check("tbl_rsp_valid", 64'(rsp_valid), 64'(N'(1) << vecs[v].lane));
      check("tbl_rsp_p", 64'(rsp_p), 64'(vecs[v].p));
    end
    repeat (NS) step();

    // fairness: pointer restarted from 0 by reset, all lanes busy for 12 cycles
    ap_rst_n = 1'b0;
    step();
    ap_rst_n = 1'b1;
    lane_v = '1;
    drive();
    for (int i = 0; i < 12; i++) begin
      step();
      check("fair_grant", 64'(dut_ready), 64'(N'(1) << (i % N)));
      for (int l = 0; l < N; l++) if (m_gnt[l]) new_operands(l);
      drive();
    end
    lane_v = '0;
    drive();
    repeat (NS + 1) step();

    // drain: two issues, then en drops with lane 2 still requesting
    lane_v = 4'b0001;
    drive();
    step();
    lane_v = 4'b0010;
    drive();
    step();
    en = 1'b0;
    lane_v = 4'b0100;
    drive();
    step();
    step();
    check("drain_busy", 64'(busy), 64'd0);
    check("drain_no_grant", 64'(dut_ready), 64'd0);
    en = 1'b1;
    step();
    lane_v = '0;
    drive();
    repeat (NS + 1) step();

    // reset while lane 3 is in flight
    lane_v = 4'b1000;
    drive();
    step();
    lane_v = '0;
    drive();
    ap_rst_n = 1'b0;
    step();
    ap_rst_n = 1'b1;
    repeat (NS + 2) begin
      step();
      check("midrst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    lane_v = '1;
    drive();
    step();
    check("midrst_ptr0", 64'(dut_ready), 64'd1);
    m_gnt = '1;
    lane_v = '0;
    drive();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 9) != 0);
      refresh((i < 300) ? 60 : 20);
      step();
    end

    en = 1'b1;
    lane_v = '0;
    drive();
    repeat (NS + 2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end
endmodule
